// File: rtl/ddr_req_arbiter_pkg.sv
// Shared definitions for the DDR request arbiter: FSM encodings, DONE bubble length
// and an index-width helper.
package ddr_req_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Cycles spent in DONE so a finished requester can drop s_valid before re-arbitration.
  localparam int DONE_CYCLES = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_req_arbiter_rr_pick.sv
// Round-robin winner selection: first requesting index after 'last', with wrap-around.
module ddr_arb_rr_pick
  import ddr_req_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] gnt
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = LW'((int'(last) + off) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing one simple memory port among N_REQ native requesters,
// with a sticky watchdog flag for memory transactions that never complete.
//
// state | meaning
// IDLE  | waiting for any s_valid; selects and latches the winner
// REQ   | m_valid high with latched fields until m_ready
// DONE  | bubble with grant=0 so the winner can drop s_valid
module ddr_req_arbiter
  import ddr_req_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           s_valid,
  input  logic [N_REQ*ADDR_W-1:0]    s_addr,
  input  logic [N_REQ*DATA_W-1:0]    s_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  s_wstrb,
  output logic [N_REQ*DATA_W-1:0]    s_rdata,
  output logic [N_REQ-1:0]           s_ready,
  output logic                       m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_ready,
  output logic [N_REQ-1:0]           grant,
  output logic                       timeout_err
);

  localparam int LW = idx_w(N_REQ);
  localparam int SW = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [LW-1:0]        last_q, last_d;
  logic [LW-1:0]        win_q, win_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 to_q, to_d;
  logic [1:0]           bub_q, bub_d;

  logic [N_REQ-1:0]     pick_gnt;
  logic [LW-1:0]        pick_idx;

  ddr_arb_rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
    .req  (s_valid),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = LW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wd_d    = wd_q;
    to_d    = to_q;
    bub_d   = bub_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_valid) begin
          grant_d = pick_gnt;
          win_d   = pick_idx;
          addr_d  = s_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = s_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          wstrb_d = s_wstrb[int'(pick_idx)*SW +: SW];
          wd_d    = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Flag on the edge the counter reaches all-ones, even if m_ready also arrives.
        if (wd_q >= WD_MAX - 1'b1) to_d = 1'b1;
        if (m_ready) begin
          last_d  = win_q;
          grant_d = '0;
          bub_d   = '0;
          state_d = ST_DONE;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bub_q == 2'(DONE_CYCLES - 1)) state_d = ST_IDLE;
        else                              bub_d   = bub_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(N_REQ - 1);
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    if (state_q == ST_REQ && m_ready) begin
      s_ready                             = grant_q;
      s_rdata[int'(win_q)*DATA_W +: DATA_W] = m_rdata;
    end
  end

  assign m_valid     = (state_q == ST_REQ);
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign grant       = grant_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_ddr_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TW = 4;
  localparam int TO_CYCLES = (1 << TW) - 1;

  logic              clk;
  logic              rst;
  logic [N-1:0]      s_valid;
  logic [N*AW-1:0]   s_addr;
  logic [N*DW-1:0]   s_wdata;
  logic [N*SW-1:0]   s_wstrb;
  logic [N*DW-1:0]   s_rdata;
  logic [N-1:0]      s_ready;
  logic              m_valid;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;
  logic [N-1:0]      grant;
  logic              timeout_err;

  logic [AW-1:0] tb_addr  [N];
  logic [DW-1:0] tb_wdata [N];
  logic [SW-1:0] tb_wstrb [N];
  logic [N-1:0]  tb_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int last_win;
  bit exp_to;

  ddr_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .m_ready(m_ready), .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_valid = tb_valid;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i*AW +: AW]  = tb_addr[i];
      s_wdata[i*DW +: DW] = tb_wdata[i];
      s_wstrb[i*SW +: SW] = tb_wstrb[i];
    end
  end

  function automatic int model_pick(input logic [N-1:0] mask, input int last);
    for (int off = 1; off <= N; off++) begin
      if (mask[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; tb_valid = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_win = N - 1;
    exp_to = 1'b0;
  endtask

  // One complete transaction; DUT must be idle when called.
  task automatic do_txn(input logic [N-1:0] mask, input int lat, input int exp_win,
                        input logic [DW-1:0] rd, input bit mutate, input string tag);
    logic [N-1:0]    oh;
    logic [AW-1:0]   a0;
    logic [DW-1:0]   d0;
    logic [SW-1:0]   w0;
    logic [N*DW-1:0] exp_rd;
    oh = '0; oh[exp_win] = 1'b1;
    a0 = tb_addr[exp_win]; d0 = tb_wdata[exp_win]; w0 = tb_wstrb[exp_win];
    exp_rd = '0; exp_rd[exp_win*DW +: DW] = rd;
    @(posedge clk); #1;
    tb_valid = mask; m_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL %s select_cycle: m_valid=%b grant=%b required 0/00", tag, m_valid, grant);
    end
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == lat) begin
        m_ready = 1'b1; m_rdata = rd;
      end else if (mutate) begin
        tb_addr[exp_win] = $urandom; tb_wdata[exp_win] = $urandom;
        tb_valid[exp_win] = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || grant !== oh) begin
        n_fail++;
        $display("FAIL %s req_grant k=%0d: m_valid=%b grant=%b required 1/%b", tag, k, m_valid, grant, oh);
      end
      n_checks++;
      if (m_addr !== a0 || m_wdata !== d0 || m_wstrb !== w0) begin
        n_fail++;
        $display("FAIL %s req_fields k=%0d: addr=%h wdata=%h wstrb=%h required %h %h %h",
                 tag, k, m_addr, m_wdata, m_wstrb, a0, d0, w0);
      end
      n_checks++;
      if (timeout_err !== exp_to) begin
        n_fail++;
        $display("FAIL %s timeout k=%0d: timeout_err=%b required %b", tag, k, timeout_err, exp_to);
      end
      n_checks++;
      if (s_ready !== ((k == lat) ? oh : '0)) begin
        n_fail++;
        $display("FAIL %s s_ready k=%0d: got %b required %b", tag, k, s_ready, (k == lat) ? oh : '0);
      end
      if (k == lat) begin
        n_checks++;
        if (s_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL %s s_rdata: got %h required %h", tag, s_rdata, exp_rd);
        end
      end
      if (k + 1 >= TO_CYCLES) exp_to = 1'b1;
    end
    @(posedge clk); #1;
    m_ready = 1'b0; m_rdata = $urandom;
    tb_valid = mask & ~oh;
    tb_addr[exp_win] = a0; tb_wdata[exp_win] = d0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || grant !== '0 || s_ready !== '0) begin
      n_fail++;
      $display("FAIL %s done_bubble: m_valid=%b grant=%b s_ready=%b required 0/00/00",
               tag, m_valid, grant, s_ready);
    end
    last_win = exp_win;
  endtask

  task automatic test_reset();
    tb_addr[0] = 32'h1111_0000; tb_addr[1] = 32'h2222_0000;
    tb_wdata[0] = 32'hA0A0_A0A0; tb_wdata[1] = 32'hB1B1_B1B1;
    tb_wstrb[0] = 4'h0; tb_wstrb[1] = 4'h0;
    m_rdata = '0;
    do_reset();
    @(posedge clk); #1; rst = 1'b1; tb_valid = 2'b11;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || grant !== '0 || s_ready !== '0 || timeout_err !== 1'b0 ||
        m_addr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin
      n_fail++;
      $display("FAIL reset_state: m_valid=%b grant=%b s_ready=%b to=%b addr=%h wdata=%h wstrb=%h required all zero",
               m_valid, grant, s_ready, timeout_err, m_addr, m_wdata, m_wstrb);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_valid: m_valid=%b required 0", m_valid);
    end
  endtask

  task automatic test_alternation();
    do_txn(2'b11, 0, 0, 32'h0000_0001, 1'b0, "alt0");
    do_txn(2'b11, 0, 1, 32'h0000_0002, 1'b0, "alt1");
    do_txn(2'b11, 1, 0, 32'h0000_0003, 1'b0, "alt2");
  endtask

  task automatic test_single_write();
    tb_addr[1] = 32'h0000_0100; tb_wstrb[1] = 4'hF; tb_wdata[1] = 32'hCAFE_F00D;
    do_txn(2'b10, 2, 1, 32'h5555_5555, 1'b0, "write1");
  endtask

  task automatic test_read();
    tb_addr[0] = 32'h0000_0040; tb_wstrb[0] = 4'h0;
    do_txn(2'b01, 1, 0, 32'hDEAD_BEEF, 1'b0, "read0");
  endtask

  task automatic test_addr_hold();
    tb_addr[0] = 32'h0000_0ABC; tb_wstrb[0] = 4'h3;
    do_txn(2'b01, 3, 0, 32'h1234_5678, 1'b1, "addr_hold");
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1; tb_valid = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || s_ready !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_req2: m_valid=%b s_ready=%b required 1/00", m_valid, s_ready);
    end
    @(posedge clk); #1; rst = 1'b0; tb_valid = '0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || grant !== '0 || s_ready !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_after: m_valid=%b grant=%b s_ready=%b required 0/00/00", m_valid, grant, s_ready);
    end
    last_win = N - 1;
    exp_to = 1'b0;
    do_txn(2'b11, 1, 0, 32'h0BAD_F00D, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [N-1:0] mask;
    int w;
    pending = tb_valid;
    for (int t = 0; t < 40; t++) begin
      mask = pending | N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (mask[i] && !pending[i]) begin
          tb_addr[i] = $urandom; tb_wdata[i] = $urandom; tb_wstrb[i] = SW'($urandom);
        end
      end
      w = model_pick(mask, last_win);
      do_txn(mask, $urandom_range(0, 6), w, $urandom, 1'($urandom_range(0, 1)), "rand");
      pending = tb_valid;
    end
    @(posedge clk); #1; tb_valid = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    do_txn(2'b01, TO_CYCLES - 2, 0, 32'h0000_00AA, 1'b0, "to_short");
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_short_flag: timeout_err=%b required 0", timeout_err);
    end
    do_txn(2'b01, TO_CYCLES - 1, 0, 32'h0000_00BB, 1'b0, "to_same_cycle");
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_same_cycle_flag: timeout_err=%b required 1", timeout_err);
    end
    do_reset();
    do_txn(2'b01, 20, 0, 32'h0000_00CC, 1'b0, "to_withheld");
    do_txn(2'b10, 1, 1, 32'h0000_00DD, 1'b0, "to_sticky");
    do_reset();
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_cleared_by_rst: timeout_err=%b required 0", timeout_err);
    end
  endtask

  initial begin
    rst = 1'b1; tb_valid = '0; m_ready = 1'b0; m_rdata = '0;
    for (int i = 0; i < N; i++) begin
      tb_addr[i] = '0; tb_wdata[i] = '0; tb_wstrb[i] = '0;
    end
    test_reset();
    test_alternation();
    test_single_write();
    test_read();
    test_addr_hold();
    test_reset_mid_req();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
